// File: rtl/ysyx_22041207_mdu_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// The EX stage drives operands and takes results; the unit is the slave.
interface ysyx_22041207_mdu_if #(
  parameter int XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;

  modport master (
    output in_valid, op, word, a, b, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, op, word, a, b, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/ysyx_22041207_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// both on operand magnitudes with the sign applied when the result is produced.
module ysyx_22041207_mdu #(
  parameter int XLEN     = 64,
  parameter bit FAST_MUL = 1'b0
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  ysyx_22041207_mdu_if.slave bus
);
  localparam int              CW    = $clog2(XLEN);
  localparam logic [XLEN-1:0] WMASK = XLEN'(64'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = XLEN'(32'h8000_0000);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [2:0]          op_reg, op_next;
  logic                word_reg, word_next;
  logic                prep_reg, prep_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next, x_reg, x_next;
  logic [XLEN-1:0]     y_reg, y_next, res_reg, res_next;

  logic [XLEN-1:0]     a_raw, a_ext, b_ext, a_mag, b_mag, nmask, a_sext, special_res;
  logic                a_neg, b_neg, b_zero, ovf, is_div, fast;
  logic [CW-1:0]       last_cnt;
  logic [XLEN:0]       diff;
  logic [2*XLEN-1:0]   acc_step, x_step, prod_s;
  logic [XLEN-1:0]     y_step, quo_s, rem_s, pick, result;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // The first CALC cycle decodes the raw operands still parked in x_reg/y_reg.
  assign is_div   = op_reg[2];
  assign a_raw    = x_reg[XLEN-1:0];
  assign nmask    = word_reg ? WMASK : '1;
  assign a_ext    = a_raw & nmask;
  assign b_ext    = y_reg & nmask;
  assign a_neg    = (op_reg[1:0] != 2'd3) && (!is_div || !op_reg[0]) &&
                    (word_reg ? a_raw[31] : a_raw[XLEN-1]);
  assign b_neg    = (is_div ? !op_reg[0] : !op_reg[1]) &&
                    (word_reg ? y_reg[31] : y_reg[XLEN-1]);
  assign a_mag    = a_neg ? ((-a_ext) & nmask) : a_ext;
  assign b_mag    = b_neg ? ((-b_ext) & nmask) : b_ext;
  assign b_zero   = (b_ext == '0);
  assign ovf      = is_div && !op_reg[0] && (b_ext == nmask) &&
                    (a_ext == (word_reg ? MIN_W : MIN_X));
  assign a_sext   = word_reg ? sext32(a_raw[31:0]) : a_raw;
  assign special_res = (b_zero && !op_reg[1]) ? '1 :
                       (ovf && op_reg[1])     ? '0 : a_sext;
  assign fast     = FAST_MUL && !is_div;
  assign last_cnt = fast ? '0 : (word_reg ? CW'(31) : CW'(XLEN - 1));

  // One iteration: restoring-divide step on {rem, quo} or shift-add multiply step.
  assign diff = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, y_reg};

  always_comb begin
    acc_step = acc_reg;
    x_step   = x_reg << 1;
    y_step   = y_reg >> 1;
    if (is_div) begin
      x_step   = x_reg;
      y_step   = y_reg;
      acc_step = diff[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end else if (fast) begin
      acc_step = x_reg * {{XLEN{1'b0}}, y_reg};
    end else if (y_reg[0]) begin
      acc_step = acc_reg + x_reg;
    end
  end

  assign prod_s = neg_q_reg ? -acc_step : acc_step;
  assign quo_s  = neg_q_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
  assign rem_s  = neg_r_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
  assign pick   = is_div ? (op_reg[1] ? rem_s : quo_s) :
                  ((op_reg[1:0] == 2'd0) || word_reg) ? prod_s[XLEN-1:0]
                                                      : prod_s[2*XLEN-1:XLEN];
  assign result = word_reg ? sext32(pick[31:0]) : pick;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    word_next  = word_reg;
    prep_next  = prep_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    acc_next   = acc_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    res_next   = res_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = CALC;
          prep_next  = 1'b1;
          cnt_next   = '0;
          op_next    = bus.op;
          word_next  = bus.word;
          x_next     = {{XLEN{1'b0}}, bus.a};
          y_next     = bus.b;
        end
      end
      CALC: begin
        if (prep_reg) begin
          prep_next = 1'b0;
          if (is_div && (b_zero || ovf)) begin
            state_next = DONE;
            res_next   = special_res;
          end else begin
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            x_next     = {{XLEN{1'b0}}, a_mag};
            y_next     = b_mag;
            // Word dividends are left-aligned so quotient bits land in [31:0].
            acc_next   = is_div ? {{XLEN{1'b0}}, (word_reg ? (a_mag << (XLEN - 32)) : a_mag)}
                                : '0;
          end
        end else begin
          acc_next = acc_step;
          x_next   = x_step;
          y_next   = y_step;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == last_cnt) begin
            state_next = DONE;
            cnt_next   = '0;
            res_next   = result;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
      prep_next  = 1'b0;
      res_next   = res_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      word_reg  <= 1'b0;
      prep_reg  <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      acc_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      word_reg  <= word_next;
      prep_reg  <= prep_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      acc_reg   <= acc_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      res_reg   <= res_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.res       = res_reg;
endmodule

// File: tb/tb_ysyx_22041207_mdu.sv
// Self-checking bench for the multiply/divide unit: directed vectors, randomized
// operations against an arithmetic reference, and flush/reset/backpressure sequences.
module tb_ysyx_22041207_mdu;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  ysyx_22041207_mdu_if #(.XLEN(XLEN)) bus ();
  ysyx_22041207_mdu #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_res = 64'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic w, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] exp, input int lat);
    vec_t v;
    v.op = op; v.w = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Reference: RISC-V M semantics computed with wide plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic [31:0]        r32;
    logic signed [31:0] sa32, sb32, sq32, sr32;
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        r;
    logic               ovf32, ovf64;
    sa32 = a[31:0]; sb32 = b[31:0]; sa = a; sb = b;
    sq32 = 0; sr32 = 0; sq = 0; sr = 0;
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (b[31:0] != 0 && !ovf32) begin sq32 = sa32 / sb32; sr32 = sa32 % sb32; end
    if (b != 0 && !ovf64) begin sq = sa / sb; sr = sa % sb; end
    if (w) begin
      r32 = a[31:0] * b[31:0];
      if (op == 3'd4) begin
        if (b[31:0] == 0) r32 = 32'hFFFF_FFFF; else if (ovf32) r32 = a[31:0]; else r32 = sq32;
      end else if (op == 3'd5) begin
        if (b[31:0] == 0) r32 = 32'hFFFF_FFFF; else r32 = a[31:0] / b[31:0];
      end else if (op == 3'd6) begin
        if (b[31:0] == 0) r32 = a[31:0]; else if (ovf32) r32 = 32'd0; else r32 = sr32;
      end else if (op == 3'd7) begin
        if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      end
      return {{32{r32[31]}}, r32};
    end
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: begin if (b == 0) r = '1; else if (ovf64) r = a; else r = sq; end
      3'd5: begin if (b == 0) r = '1; else r = a / b; end
      3'd6: begin if (b == 0) r = a; else if (ovf64) r = 64'd0; else r = sr; end
      default: begin if (b == 0) r = a; else r = a % b; end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (op[2] && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] rnd_operand();
    logic signed [63:0] s;
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: begin s = 64'($urandom_range(0, 16)); return s - 64'sd8; end
      2: return 64'd0;
      3: return '1;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, 32'h8000_0000};
    endcase
  endfunction

  // Issue one op, measure edges from accept to out_valid, optionally stall the result.
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold,
                        output logic [63:0] got, output int lat);
    bit busy_bad;
    chk("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.op = op; bus.word = w; bus.a = a; bus.b = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    bus.op = 3'($urandom);
    bus.word = 1'($urandom);
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("in_ready_low_while_busy", busy_bad, 1'b0);
    chk("out_valid_within_bound", bus.out_valid, 1'b1);
    got = bus.res;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_res", bus.res, got);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_handshake_out_valid", bus.out_valid, 1'b0);
    chk("post_handshake_in_ready", bus.in_ready, 1'b1);
    last_res = got;
    $display("op=%0d w=%0b a=%h b=%h res=%h lat=%0d", op, w, a, b, got, lat);
  endtask

  task automatic start_and_wait(input int cycles);
    bus.op = 3'd4; bus.word = 1'b0; bus.a = 64'd1000; bus.b = 64'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (cycles - 1) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [63:0] got;
    int          lat;
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = 3'd0; bus.word = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_res", bus.res, 64'd0);
    rst = 1'b0;

    vecs.push_back(mk(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65));
    vecs.push_back(mk(3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65));
    vecs.push_back(mk(3'd1, 1'b0, '1, '1, 64'h0, 65));
    vecs.push_back(mk(3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65));
    vecs.push_back(mk(3'd0, 1'b0, '1, '1, 64'h1, 65));
    vecs.push_back(mk(3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1));
    vecs.push_back(mk(3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1));
    vecs.push_back(mk(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1));
    vecs.push_back(mk(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1));
    vecs.push_back(mk(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65));
    vecs.push_back(mk(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65));
    vecs.push_back(mk(3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33));
    vecs.push_back(mk(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33));
    vecs.push_back(mk(3'd0, 1'b1, 64'h8000_0000, 64'd2, 64'h0, 33));
    vecs.push_back(mk(3'd3, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33));
    vecs.push_back(mk(3'd7, 1'b1, 64'h0000_0000_8000_0000, 64'hAB00_0000_0000_0000,
                      64'hFFFF_FFFF_8000_0000, 1));
    vecs.push_back(mk(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65));

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 0, got, lat);
      chk($sformatf("vec%0d_res", i), got, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: result held for five cycles.
    run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5, got, lat);
    chk("bp_res", got, 64'hFFFF_FFFF_FFFF_FFFD);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      ra  = rnd_operand();
      rb  = rnd_operand();
      run_op(rop, rw, ra, rb, 0, got, lat);
      chk($sformatf("rand%0d_res", i), got, model(rop, rw, ra, rb));
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(model_lat(rop, rw, ra, rb)));
    end

    // Flush in CALC cycle 10 with a competing in_valid.
    start_and_wait(10);
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'd5; bus.a = 64'd100; bus.b = 64'd7;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_res_kept", bus.res, last_res);
    @(posedge clk); #1;
    chk("flush_nothing_accepted", bus.in_ready, 1'b1);
    run_op(3'd5, 1'b0, 64'd100, 64'd7, 0, got, lat);
    chk("after_flush_divu", got, 64'd14);
    chk("after_flush_latency", 64'(lat), 64'd65);

    // Reset in CALC cycle 10.
    start_and_wait(10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_res", bus.res, 64'd0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    run_op(3'd0, 1'b0, 64'd3, 64'd4, 0, got, lat);
    chk("after_rst_mul", got, 64'd12);

    // Flush while DONE is stalled.
    bus.op = 3'd4; bus.word = 1'b0; bus.a = 64'd9; bus.b = 64'd0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_stall_out_valid", bus.out_valid, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("done_flush_out_valid", bus.out_valid, 1'b0);
    chk("done_flush_in_ready", bus.in_ready, 1'b1);
    chk("done_flush_res_kept", bus.res, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
